// File: rtl/dmem_pkg.sv
// +----------------------------------------------------------------------------+
// | dmem_pkg : shared types and constants for the Data_Memory arbiter          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

   localparam int DMEM_DEPTH = 64;
   localparam int DMEM_AW    = 32;
   localparam int DMEM_DW    = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic               we;
      logic [DMEM_AW-1:0] addr;
      logic [DMEM_DW-1:0] wdata;
   } dmem_req_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// +----------------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin picker; a tie goes to the port not in 'last' |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] gnt
);

   assign gnt[0] = valid[0] & (~valid[1] |  last);
   assign gnt[1] = valid[1] & (~valid[0] | ~last);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +----------------------------------------------------------------------------+
// | dmem_arbiter : round-robin sequencer sharing Data_Memory between m0 / m1   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH,
   parameter int AW    = DMEM_AW,
   parameter int DW    = DMEM_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req_valid,
   output logic          m0_req_ready,
   input  logic          m0_req_we,
   input  logic [AW-1:0] m0_req_addr,
   input  logic [DW-1:0] m0_req_wdata,
   output logic          m0_rsp_valid,
   input  logic          m0_rsp_ready,
   output logic [DW-1:0] m0_rsp_rdata,
   output logic          m0_rsp_err,
   input  logic          m1_req_valid,
   output logic          m1_req_ready,
   input  logic          m1_req_we,
   input  logic [AW-1:0] m1_req_addr,
   input  logic [DW-1:0] m1_req_wdata,
   output logic          m1_rsp_valid,
   input  logic          m1_rsp_ready,
   output logic [DW-1:0] m1_rsp_rdata,
   output logic          m1_rsp_err,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd
);

   localparam logic [AW-3:0] C_DEPTH = (AW-2)'(DEPTH);

   dmem_state_e   r_state;
   logic          r_owner;
   logic          r_last;
   dmem_req_t     r_req;
   logic          r_err;
   logic [DW-1:0] r_rsp_rdata;
   logic          r_rsp_err;

   logic [1:0]    w_gnt;
   dmem_req_t     w_sel;
   logic          w_sel_err;
   logic          w_idle;
   logic          w_access;
   logic          w_resp;
   logic          w_rsp_ready;

   rr_arb2 u_arb (
      .valid ({m1_req_valid, m0_req_valid}),
      .last  (r_last),
      .gnt   (w_gnt)
   );

   assign w_sel.we    = w_gnt[1] ? m1_req_we    : m0_req_we;
   assign w_sel.addr  = w_gnt[1] ? m1_req_addr  : m0_req_addr;
   assign w_sel.wdata = w_gnt[1] ? m1_req_wdata : m0_req_wdata;

   // Faults are resolved at accept time so ACCESS can gate the write without extra decode.
   assign w_sel_err = (w_sel.addr[1:0] != 2'b00) || (w_sel.addr[AW-1:2] >= C_DEPTH);

   // rst_n gates ready so nothing appears accepted while reset is held.
   assign w_idle   = (r_state == IDLE) && rst_n;
   assign w_access = (r_state == ACCESS);
   assign w_resp   = (r_state == RESP);

   assign m0_req_ready = w_idle & w_gnt[0];
   assign m1_req_ready = w_idle & w_gnt[1];

   assign w_rsp_ready = r_owner ? m1_rsp_ready : m0_rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_owner     <= 1'b0;
         r_last      <= 1'b1;
         r_req       <= '0;
         r_err       <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|w_gnt) begin
                  r_owner <= w_gnt[1];
                  r_last  <= w_gnt[1];
                  r_req   <= w_sel;
                  r_err   <= w_sel_err;
                  r_state <= ACCESS;
               end
            end
            ACCESS: begin
               r_rsp_rdata <= (r_req.we | r_err) ? '0 : mem_rd;
               r_rsp_err   <= r_err;
               r_state     <= RESP;
            end
            RESP: begin
               if (w_rsp_ready) begin
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign m0_rsp_valid = w_resp & ~r_owner;
   assign m1_rsp_valid = w_resp &  r_owner;
   assign m0_rsp_rdata = m0_rsp_valid ? r_rsp_rdata : '0;
   assign m1_rsp_rdata = m1_rsp_valid ? r_rsp_rdata : '0;
   assign m0_rsp_err   = m0_rsp_valid & r_rsp_err;
   assign m1_rsp_err   = m1_rsp_valid & r_rsp_err;

   // Memory pins are decoded from the state register only, so they are quiet outside ACCESS.
   assign mem_we = w_access & r_req.we & ~r_err;
   assign mem_a  = w_access ? r_req.addr  : '0;
   assign mem_wd = w_access ? r_req.wdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_dmem_arbiter : directed vector bench for dmem_arbiter with memory model |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_req_valid = 1'b0, m0_req_we = 1'b0;
   logic [31:0] m0_req_addr = '0, m0_req_wdata = '0;
   logic        m0_rsp_ready = 1'b1;
   logic        m1_req_valid = 1'b0, m1_req_we = 1'b0;
   logic [31:0] m1_req_addr = '0, m1_req_wdata = '0;
   logic        m1_rsp_ready = 1'b1;
   logic        m0_req_ready, m0_rsp_valid, m0_rsp_err;
   logic        m1_req_ready, m1_rsp_valid, m1_rsp_err;
   logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
   logic        mem_we;
   logic [31:0] mem_a, mem_wd, mem_rd;

   int n_vec  = 0;
   int n_fail = 0;

   logic [31:0] mem [0:63];
   bit          mem_inited = 1'b0;
   int          we_cnt = 0;

   dmem_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .m0_req_valid (m0_req_valid),
      .m0_req_ready (m0_req_ready),
      .m0_req_we    (m0_req_we),
      .m0_req_addr  (m0_req_addr),
      .m0_req_wdata (m0_req_wdata),
      .m0_rsp_valid (m0_rsp_valid),
      .m0_rsp_ready (m0_rsp_ready),
      .m0_rsp_rdata (m0_rsp_rdata),
      .m0_rsp_err   (m0_rsp_err),
      .m1_req_valid (m1_req_valid),
      .m1_req_ready (m1_req_ready),
      .m1_req_we    (m1_req_we),
      .m1_req_addr  (m1_req_addr),
      .m1_req_wdata (m1_req_wdata),
      .m1_rsp_valid (m1_rsp_valid),
      .m1_rsp_ready (m1_rsp_ready),
      .m1_rsp_rdata (m1_rsp_rdata),
      .m1_rsp_err   (m1_rsp_err),
      .mem_we       (mem_we),
      .mem_a        (mem_a),
      .mem_wd       (mem_wd),
      .mem_rd       (mem_rd)
   );

   always #5 clk = ~clk;

   // Data_Memory model: word 0 = FACEFACE, word i = i+1 otherwise.
   assign mem_rd = mem[mem_a[7:2]];
   always @(posedge clk) begin
      if (!mem_inited) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'(i + 1);
         mem[0]     <= 32'hFACEFACE;
         mem_inited <= 1'b1;
      end else if (mem_we) begin
         mem[mem_a[7:2]] <= mem_wd;
         we_cnt          <= we_cnt + 1;
      end
   end

   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit port, input bit v, input bit we,
                        input logic [31:0] a, input logic [31:0] d);
      if (port) begin
         m1_req_valid = v; m1_req_we = we; m1_req_addr = a; m1_req_wdata = d;
      end else begin
         m0_req_valid = v; m0_req_we = we; m0_req_addr = a; m0_req_wdata = d;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on a single port; entered and left at posedge+1 in IDLE.
   task automatic apply(input int idx, input vec_t v);
      int  we0;
      bit  exp_we;
      string tag;
      tag    = $sformatf("vec%0d", idx);
      exp_we = v.we & ~v.exp_err;
      we0    = we_cnt;
      drive(v.port, 1'b1, v.we, v.addr, v.wdata);
      @(negedge clk);
      chk({tag, " req_ready"}, 32'(v.port ? m1_req_ready : m0_req_ready), 32'd1);
      chk({tag, " other req_ready"}, 32'(v.port ? m0_req_ready : m1_req_ready), 32'd0);
      step();
      drive(v.port, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      chk({tag, " mem_we"}, 32'(mem_we), 32'(exp_we));
      chk({tag, " mem_a"}, mem_a, v.addr);
      if (exp_we) chk({tag, " mem_wd"}, mem_wd, v.wdata);
      step();
      @(negedge clk);
      chk({tag, " rsp_valid"}, 32'(v.port ? m1_rsp_valid : m0_rsp_valid), 32'd1);
      chk({tag, " other rsp_valid"}, 32'(v.port ? m0_rsp_valid : m1_rsp_valid), 32'd0);
      chk({tag, " rsp_rdata"}, v.port ? m1_rsp_rdata : m0_rsp_rdata, v.exp_rdata);
      chk({tag, " rsp_err"}, 32'(v.port ? m1_rsp_err : m0_rsp_err), 32'(v.exp_err));
      step();
      @(negedge clk);
      chk({tag, " rsp_valid after handshake"}, 32'(m0_rsp_valid | m1_rsp_valid), 32'd0);
      chk({tag, " write count"}, 32'(we_cnt - we0), 32'(exp_we));
      step();
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hFACEFACE, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0008, 32'hDEADBEEF,  32'h0,        1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'hDEADBEEF, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_0006, 32'h1111_1111, 32'h0,        1'b1};
      vecs[4] = '{1'b0, 1'b1, 32'h0000_0100, 32'h2222_2222, 32'h0,        1'b1};
      vecs[5] = '{1'b0, 1'b0, 32'h0000_00FC, 32'h0,         32'd64,       1'b0};
      vecs[6] = '{1'b1, 1'b0, 32'h0000_0006, 32'h0,         32'h0,        1'b1};
      vecs[7] = '{1'b1, 1'b1, 32'h0000_00FC, 32'hA5A5A5A5,  32'h0,        1'b0};
      vecs[8] = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,         32'hA5A5A5A5, 1'b0};

      // Reset with both requesters valid: every output must stay 0.
      drive(1'b0, 1'b1, 1'b1, 32'h4, 32'h5);
      drive(1'b1, 1'b1, 1'b1, 32'h8, 32'h9);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset m0_req_ready", 32'(m0_req_ready), 32'd0);
      chk("reset m1_req_ready", 32'(m1_req_ready), 32'd0);
      chk("reset mem_we", 32'(mem_we), 32'd0);
      chk("reset mem_a", mem_a, 32'd0);
      chk("reset mem_wd", mem_wd, 32'd0);
      chk("reset rsp_valid", 32'({m1_rsp_valid, m0_rsp_valid}), 32'd0);
      chk("reset rsp_rdata", m0_rsp_rdata | m1_rsp_rdata, 32'd0);
      chk("reset rsp_err", 32'({m1_rsp_err, m0_rsp_err}), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 9; i++) apply(i, vecs[i]);

      // Both ports continuously valid: grants alternate starting with m0.
      drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("rr%0d m0_req_ready", i), 32'(m0_req_ready), 32'(i % 2 == 0));
         chk($sformatf("rr%0d m1_req_ready", i), 32'(m1_req_ready), 32'(i % 2 == 1));
         step();
         step();
         @(negedge clk);
         chk($sformatf("rr%0d m0_rsp_valid", i), 32'(m0_rsp_valid), 32'(i % 2 == 0));
         chk($sformatf("rr%0d m1_rsp_valid", i), 32'(m1_rsp_valid), 32'(i % 2 == 1));
         chk($sformatf("rr%0d rdata", i), m0_rsp_rdata | m1_rsp_rdata,
             (i % 2 == 1) ? 32'd10 : 32'd9);
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // m0 response stalled five cycles while m1 waits.
      m0_rsp_ready = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      chk("bp m0_req_ready", 32'(m0_req_ready), 32'd1);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
      @(negedge clk);
      chk("bp m1_req_ready in ACCESS", 32'(m1_req_ready), 32'd0);
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp%0d m0_rsp_valid", i), 32'(m0_rsp_valid), 32'd1);
         chk($sformatf("bp%0d m0_rsp_rdata", i), m0_rsp_rdata, 32'd5);
         chk($sformatf("bp%0d m1_req_ready", i), 32'(m1_req_ready), 32'd0);
         step();
      end
      m0_rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp m0_rsp_valid at handshake", 32'(m0_rsp_valid), 32'd1);
      step();
      @(negedge clk);
      chk("bp m1_req_ready after handshake", 32'(m1_req_ready), 32'd1);
      chk("bp m0_rsp_valid cleared", 32'(m0_rsp_valid), 32'd0);
      step();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      @(negedge clk);
      chk("bp m1_rsp_valid", 32'(m1_rsp_valid), 32'd1);
      chk("bp m1_rsp_rdata", m1_rsp_rdata, 32'd6);
      step();
      step();

      // Asynchronous reset during the ACCESS cycle of a store.
      drive(1'b0, 1'b1, 1'b1, 32'h4, 32'h12345678);
      @(negedge clk);
      chk("arst m0_req_ready", 32'(m0_req_ready), 32'd1);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("arst mem_we before reset", 32'(mem_we), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst mem_we dropped", 32'(mem_we), 32'd0);
      chk("arst mem_a dropped", mem_a, 32'd0);
      chk("arst mem_wd dropped", mem_wd, 32'd0);
      step();
      rst_n = 1'b1;
      chk("arst word1 kept", mem[1], 32'h0000_0002);
      drive(1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
      @(negedge clk);
      chk("arst tie m0_req_ready", 32'(m0_req_ready), 32'd1);
      chk("arst tie m1_req_ready", 32'(m1_req_ready), 32'd0);
      chk("arst rsp_valid idle", 32'({m1_rsp_valid, m0_rsp_valid}), 32'd0);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      @(negedge clk);
      chk("arst reload word1", m0_rsp_rdata, 32'h0000_0002);
      chk("arst reload m0_rsp_valid", 32'(m0_rsp_valid), 32'd1);
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port, word-aligned Data_Memory (64 x 32-bit, combinational read, write on posedge clk).
- Shares the memory between the CPU load/store port (m0) and a debug/DMA port (m1) using valid/ready request and response handshakes.
- Performs round-robin grant, latches the winning request, drives the memory for exactly one cycle, and returns registered read data or an error.
- Faulting accesses (misaligned or out of range) never reach memory.

Parameters:
- DEPTH, 64, number of 32-bit words in Data_Memory; legal word index is 0..DEPTH-1.
- AW, 32, request address width (byte address).
- DW, 32, data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mN_req_valid  in  1  (N = 0,1) request valid.
- mN_req_ready  out  1  request accepted this cycle.
- mN_req_we  in  1  1 = store, 0 = load.
- mN_req_addr  in  AW  byte address.
- mN_req_wdata  in  DW  store data.
- mN_rsp_valid  out  1  response valid.
- mN_rsp_ready  in  1  requester takes the response.
- mN_rsp_rdata  out  DW  load data; 0 for stores and errors.
- mN_rsp_err  out  1  misaligned or out-of-range access.
- mem_we  out  1  to Data_Memory WE.
- mem_a  out  AW  to Data_Memory A.
- mem_wd  out  DW  to Data_Memory WD.
- mem_rd  in  DW  from Data_Memory RD.

Behaviour:
- Reset is asynchronous: the FSM goes to IDLE immediately.
  - All outputs are 0 immediately: mem_we, mem_a, mem_wd, mN_req_ready, mN_rsp_valid, mN_rsp_rdata, mN_rsp_err.
  - The last-grant pointer resets to 1, so m0 wins the first tie.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not equal to last-grant wins.
  - The winner's req_ready is asserted combinationally in IDLE only; the loser's req_ready is 0.
  - On the clock edge: latch owner, we, addr, wdata; set last-grant = owner; go to ACCESS.
  - Compute the error flag at latch time: err = (addr[1:0] != 0) or (addr[AW-1:2] >= DEPTH).
- ACCESS (exactly 1 cycle):
  - mem_a = latched addr; mem_wd = latched wdata; mem_we = latched we & ~err.
  - The memory write commits on the edge ending ACCESS.
  - On that edge: rsp_rdata <= (we | err) ? 0 : mem_rd; rsp_err <= err; go to RESP.
- RESP:
  - The owner's rsp_valid = 1; the other port's rsp_valid = 0.
  - rdata and err are held stable until rsp_ready is sampled high.
  - Then go to IDLE and clear rsp_rdata and rsp_err to 0.
- mem_we, mem_a and mem_wd are 0 in every state except ACCESS. mem_we is decoded from the state register, so it is glitch-free and never asserted across reset.
- Latency: accept at edge T, memory access in cycle T+1, response visible in cycle T+2.
  - Minimum 3 cycles per transaction when rsp_ready is held high.
  - A new request can be accepted in the cycle after the response handshake.
- Back-pressure: while not in IDLE, both req_ready = 0. Requesters hold valid and request fields stable until ready.
- Fairness: with both ports continuously valid, grants strictly alternate (m0, m1, m0, ...). Maximum wait is one transaction.
- Simultaneous events: a new request arriving while in RESP is not accepted until IDLE. rsp_ready asserted outside RESP is ignored.
- Error accesses take the same 3-cycle path, with mem_we forced 0 in ACCESS.
- Reset mid-operation:
  - A transaction whose ACCESS edge has not occurred is lost with no write.
  - A response pending in RESP is discarded.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum {IDLE, ACCESS, RESP};
  - DMEM_DEPTH = 64;
  - the request struct {we, addr, wdata}.
- One natural sub-module: rr_arb2, a 2-way round-robin picker with inputs valid[1:0], last and output gnt[1:0].
- The FSM, latches and memory mux stay in dmem_arbiter.

Test Plan:
1. Reset -> all outputs 0 while rst_n = 0. With Data_Memory word 0 = 32'hFACEFACE, m0 loads addr 0x0 -> m0_rsp_valid in cycle T+2 with rdata = 32'hFACEFACE, err = 0.
2. m1 stores 0xDEADBEEF to 0x8, then m1 loads 0x8 -> mem_we high for exactly one cycle with mem_a = 0x8; the load returns 32'hDEADBEEF.
3. m0 and m1 both continuously valid for 6 transactions -> grant order m0, m1, m0, m1, m0, m1; each response goes to the correct port only.
4. m0 stores to 0x6 (misaligned), then to 0x100 (word 64, out of range) -> mem_we stays 0 throughout; rsp_err = 1 and rdata = 0 both times; a subsequent load of 0x100 - 4 (word 63) is unchanged.
5. m0 load with m0_rsp_ready held low for 5 cycles while m1 is valid -> m0_rsp_valid and rdata stay stable and m1_req_ready stays 0; m1 is granted on the cycle after the m0 handshake.
6. Assert rst_n = 0 asynchronously during ACCESS of a store of 0x12345678 to 0x4 -> mem_we drops immediately and word 1 keeps its old value (32'h00000002); the FSM is in IDLE after release and m0 wins the first tie.
